// File: rtl/i2s_tdm_master.sv
// i2s_tdm_master
// Audio-port master for I2S or TDM operation, running entirely in the SAICLK
// (clk) domain. BCLK is produced by a programmable divider and is only ever
// an output; all shifting and sampling are qualified by single-cycle
// edge strobes derived from the divider.
//
// Ports:
//   clk        SAICLK, the only clock
//   _reset     asynchronous active-low reset
//   enable     run when high, idle (outputs low) when low
//   mode       0 = I2S (50% LRCLK), 1 = TDM (one-BCLK frame-sync pulse)
//   bclk_div   BCLK half-period minus 1, in clk cycles
//   tx_data    CHANNELS slots, slot k at [k*WIDTH +: WIDTH]
//   tx_valid   tx_data holds a new frame
//   tx_ready   holding register is empty
//   rx_data    last complete received frame, same packing as tx_data
//   rx_valid   one-clk pulse when rx_data updates
//   underrun   one-clk pulse when a frame is sent without new data
//   BCLK, LRCLK, DOUT  serial outputs
//   DIN        serial data input
module i2s_tdm_master #(
    parameter int WIDTH     = 24,
    parameter int SLOT_BITS = 32,
    parameter int CHANNELS  = 2
) (
    input  logic                         clk,
    input  logic                         _reset,
    input  logic                         enable,
    input  logic                         mode,
    input  logic [7:0]                   bclk_div,
    input  logic [CHANNELS*WIDTH-1:0]    tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [CHANNELS*WIDTH-1:0]    rx_data,
    output logic                         rx_valid,
    output logic                         underrun,
    output logic                         BCLK,
    output logic                         LRCLK,
    output logic                         DOUT,
    input  logic                         DIN
);

    localparam int N  = CHANNELS * WIDTH;
    localparam int BW = $clog2(SLOT_BITS);
    localparam int CW = $clog2(CHANNELS);
    localparam int IW = $clog2(N);

    localparam logic [BW-1:0] LAST_BIT  = BW'(SLOT_BITS - 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(CHANNELS - 1);
    localparam logic [CW-1:0] HALF_SLOT = CW'(CHANNELS / 2);

    // The period index p is kept as (slot_idx, bit_idx) so that slot
    // boundaries and the zero padding fall out without a divider.
    logic          running;
    logic [7:0]    div_cnt;
    logic [CW-1:0] slot_idx;
    logic [BW-1:0] bit_idx;
    logic          mode_act;

    logic [N-1:0]  hold_reg;
    logic          hold_full;
    logic [N-1:0]  tx_frame;

    logic [N-1:0]  rx_shift;
    logic          rx_armed;
    logic          rx_done;

    logic          tick;
    logic          fall_edge;
    logic          rise_edge;
    logic          p_is_zero;
    logic          p_is_one;
    logic          last_bit;
    logic          last_slot;
    logic [BW-1:0] next_bit;
    logic [CW-1:0] next_slot;
    logic          next_is_p0;
    logic          load;
    logic [N-1:0]  frame_src;
    logic [IW-1:0] tx_idx;
    logic          tx_bit;
    logic          mode_eff;
    logic          lr_next;
    logic [BW-1:0] s_bit;
    logic [CW-1:0] s_slot;
    logic          rx_in_data;
    logic [IW-1:0] rx_idx;
    logic          transfer;

    // Edge strobes, next period index and the serial bit selection.
    // DOUT for the new period carries the stream bit whose index equals the
    // old period index, so the transmit bit is picked from the current
    // (slot_idx, bit_idx). At the p=0 -> p=1 fall the frame is loaded in the
    // same cycle, so the bit is taken from the source that is being loaded.
    always_comb begin
        tick       = running && enable && (div_cnt == 8'd0);
        fall_edge  = tick && BCLK;
        rise_edge  = tick && !BCLK;
        p_is_zero  = (slot_idx == '0) && (bit_idx == '0);
        p_is_one   = (slot_idx == '0) && (bit_idx == BW'(1));
        last_bit   = (bit_idx == LAST_BIT);
        last_slot  = (slot_idx == LAST_SLOT);
        next_bit   = bit_idx + BW'(1);
        next_slot  = slot_idx;
        if (last_bit) begin
            next_bit  = '0;
            next_slot = last_slot ? '0 : slot_idx + CW'(1);
        end
        next_is_p0 = last_bit && last_slot;
        load       = fall_edge && p_is_zero;

        frame_src = tx_frame;
        if (load) begin
            frame_src = hold_full ? hold_reg : '0;
        end

        tx_idx = '0;
        tx_bit = 1'b0;
        if (int'(bit_idx) < WIDTH) begin
            tx_idx = IW'(int'(slot_idx) * WIDTH + WIDTH - 1 - int'(bit_idx));
            tx_bit = frame_src[tx_idx];
        end

        // A mode change is only adopted when a new frame starts.
        mode_eff = next_is_p0 ? mode : mode_act;
        lr_next  = mode_eff ? next_is_p0 : (next_slot >= HALF_SLOT);

        // DIN during period p carries stream bit p-1 (wrapping to F-1).
        if (bit_idx == '0) begin
            s_bit  = LAST_BIT;
            s_slot = (slot_idx == '0) ? LAST_SLOT : slot_idx - CW'(1);
        end else begin
            s_bit  = bit_idx - BW'(1);
            s_slot = slot_idx;
        end
        rx_in_data = int'(s_bit) < WIDTH;
        rx_idx     = '0;
        if (rx_in_data) begin
            rx_idx = IW'(int'(s_slot) * WIDTH + WIDTH - 1 - int'(s_bit));
        end

        transfer = tx_valid && tx_ready;
    end

    // Divider, period counter and serial outputs. The cycle in which enable
    // is first seen high acts as the start of period 0 and preloads the
    // divider, so the first BCLK rise comes bclk_div+1 clks later.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            running  <= 1'b0;
            div_cnt  <= 8'd0;
            slot_idx <= '0;
            bit_idx  <= '0;
            mode_act <= 1'b0;
            BCLK     <= 1'b0;
            LRCLK    <= 1'b0;
            DOUT     <= 1'b0;
        end else if (!enable) begin
            running  <= 1'b0;
            div_cnt  <= 8'd0;
            slot_idx <= '0;
            bit_idx  <= '0;
            BCLK     <= 1'b0;
            LRCLK    <= 1'b0;
            DOUT     <= 1'b0;
        end else if (!running) begin
            running  <= 1'b1;
            div_cnt  <= bclk_div;
            slot_idx <= '0;
            bit_idx  <= '0;
            mode_act <= mode;
            BCLK     <= 1'b0;
            LRCLK    <= mode;
            DOUT     <= 1'b0;
        end else if (div_cnt == 8'd0) begin
            div_cnt <= bclk_div;
            BCLK    <= !BCLK;
            if (BCLK) begin
                slot_idx <= next_slot;
                bit_idx  <= next_bit;
                mode_act <= mode_eff;
                LRCLK    <= lr_next;
                DOUT     <= tx_bit;
            end
        end else begin
            div_cnt <= div_cnt - 8'd1;
        end
    end

    // Holding register and frame load. A transfer coinciding with the load
    // lands in the holding register for the following frame; tx_ready
    // tracks the holding register one clk later.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            tx_ready  <= 1'b1;
            tx_frame  <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= load && !hold_full;
            if (load) begin
                tx_frame <= frame_src;
            end
            if (transfer) begin
                hold_reg  <= tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            tx_ready <= !(transfer || (hold_full && !load));
        end
    end

    // Receive path. Capture is armed by the first p=1 rise so that the
    // partial frame seen right after enable never produces rx_valid; the
    // p=0 rise then completes a frame and rx_data follows one clk later.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rx_shift <= '0;
            rx_armed <= 1'b0;
            rx_done  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= rx_done;
            rx_done  <= 1'b0;
            if (rx_done) begin
                rx_data <= rx_shift;
            end
            if (!enable) begin
                rx_armed <= 1'b0;
            end else if (rise_edge) begin
                if (rx_in_data) begin
                    rx_shift[rx_idx] <= DIN;
                end
                if (p_is_one) begin
                    rx_armed <= 1'b1;
                end
                if (p_is_zero && rx_armed) begin
                    rx_done <= 1'b1;
                end
            end
        end
    end

endmodule
